// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the RAM port arbiter: grant encoding and read-return latency.
package ram_port_arbiter_pkg;

  typedef enum logic {
    GNT_WR = 1'b0,
    GNT_RD = 1'b1
  } gnt_t;

  // Read accept to rdata_valid, in clock cycles.
  localparam int unsigned RD_LAT = 3;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Request/response and RAM-side signal bundle for ram_port_arbiter.
interface ram_port_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rdata_valid;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ram_we;
  logic                  ram_re;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, ram_rdata,
    output wr_ready, rd_ready, rdata_valid, rdata,
           ram_we, ram_re, ram_addr, ram_wdata
  );

  modport master (
    output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, ram_rdata,
    input  wr_ready, rd_ready, rdata_valid, rdata,
           ram_we, ram_re, ram_addr, ram_wdata
  );
endinterface

// File: rtl/ram_rr_arbiter.sv
// 2-way write/read grant with last-grant state; fixed write priority when
// RAM_ARB_WR_PRIORITY_EN is defined.
module ram_rr_arbiter
  import ram_port_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_wr_valid,
  input  logic i_rd_valid,
  output logic o_wr_gnt,
  output logic o_rd_gnt
);

  logic w_wr_gnt;
  logic w_rd_gnt;

`ifdef RAM_ARB_WR_PRIORITY_EN
  always_comb begin
    w_wr_gnt = 1'b0;
    w_rd_gnt = 1'b0;
    if (!rst) begin
      w_wr_gnt = i_wr_valid;
      w_rd_gnt = i_rd_valid && !i_wr_valid;
    end
  end
`else
  gnt_t r_last;

  // Contention goes to whichever channel did not win the previous handshake.
  always_comb begin
    w_wr_gnt = 1'b0;
    w_rd_gnt = 1'b0;
    if (!rst) begin
      if (i_wr_valid && i_rd_valid) begin
        w_wr_gnt = (r_last == GNT_RD);
        w_rd_gnt = (r_last == GNT_WR);
      end else begin
        w_wr_gnt = i_wr_valid;
        w_rd_gnt = i_rd_valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= GNT_RD;
    end else if (w_wr_gnt) begin
      r_last <= GNT_WR;
    end else if (w_rd_gnt) begin
      r_last <= GNT_RD;
    end
  end
`endif

  assign o_wr_gnt = w_wr_gnt;
  assign o_rd_gnt = w_rd_gnt;

endmodule

// File: rtl/ram_port_arbiter.sv
// Write/read request front-end for a single-port synchronous RAM.
// Define RAM_ARB_WR_PRIORITY_EN for fixed write priority instead of round-robin.
module ram_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  ram_port_arbiter_if.slave   bus
);

  logic                  w_wr_gnt;
  logic                  w_rd_gnt;
  logic                  w_wr_acc;
  logic                  w_rd_acc;

  logic                  r_we;
  logic                  r_re;
  logic                  r_re_d;
  logic                  r_rdata_valid;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;

  ram_rr_arbiter u_arb (
    .clk        (clk),
    .rst        (rst),
    .i_wr_valid (bus.wr_valid),
    .i_rd_valid (bus.rd_valid),
    .o_wr_gnt   (w_wr_gnt),
    .o_rd_gnt   (w_rd_gnt)
  );

  assign w_wr_acc = bus.wr_valid && w_wr_gnt;
  assign w_rd_acc = bus.rd_valid && w_rd_gnt;

  // Command register; address and write data hold whenever nothing is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_re    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_wr_acc;
      r_re <= w_rd_acc;
      if (w_wr_acc) begin
        r_addr  <= bus.wr_addr;
        r_wdata <= bus.wr_data;
      end else if (w_rd_acc) begin
        r_addr  <= bus.rd_addr;
      end
    end
  end

  // Read return: RAM data is valid the cycle after ram_re and registered once.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_re_d        <= 1'b0;
      r_rdata_valid <= 1'b0;
      r_rdata       <= '0;
    end else begin
      r_re_d        <= r_re;
      r_rdata_valid <= r_re_d;
      if (r_re_d) begin
        r_rdata <= bus.ram_rdata;
      end
    end
  end

  assign bus.wr_ready    = w_wr_gnt;
  assign bus.rd_ready    = w_rd_gnt;
  assign bus.ram_we      = r_we;
  assign bus.ram_re      = r_re;
  assign bus.ram_addr    = r_addr;
  assign bus.ram_wdata   = r_wdata;
  assign bus.rdata_valid = r_rdata_valid;
  assign bus.rdata       = r_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed self-checking bench for ram_port_arbiter with a behavioural RAM agent.
module tb_ram_port_arbiter;
  import ram_port_arbiter_pkg::*;

  typedef struct {
    int         due;
    logic [7:0] data;
  } rd_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_bad = 0;

  logic [7:0] ram_mem [16];
  logic [7:0] exp_mem [16];
  logic [3:0] m_addr;
  logic [7:0] m_wdata;
  rd_exp_t    q [$];

  ram_port_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  ram_port_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
    if (bus.ram_re) bus.ram_rdata <= ram_mem[bus.ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus.rdata_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("rdv_unexpected", bus.rdata_valid, 1'b0);
      end else begin
        rd_exp_t e;
        e = q.pop_front();
        chk("rdv_latency", cyc, e.due);
        chk("rdata", bus.rdata, e.data);
      end
    end else if (q.size() > 0 && q[0].due <= cyc) begin
      chk("rdv_missing", bus.rdata_valid, 1'b1);
      void'(q.pop_front());
    end
  end

  task automatic step(input logic wv, input logic [3:0] wa, input logic [7:0] wd,
                      input logic rv, input logic [3:0] ra,
                      input logic ew, input logic er);
    bus.wr_valid = wv;
    bus.wr_addr  = wa;
    bus.wr_data  = wd;
    bus.rd_valid = rv;
    bus.rd_addr  = ra;
    #1;
    chk("wr_ready", bus.wr_ready, ew);
    chk("rd_ready", bus.rd_ready, er);
    if (ew) begin
      exp_mem[wa] = wd;
      m_addr      = wa;
      m_wdata     = wd;
    end else if (er) begin
      q.push_back('{due: cyc + int'(RD_LAT), data: exp_mem[ra]});
      m_addr = ra;
    end
    @(posedge clk);
    #1;
    chk("ram_we", bus.ram_we, ew);
    chk("ram_re", bus.ram_re, er);
    chk("ram_addr", bus.ram_addr, m_addr);
    chk("ram_wdata", bus.ram_wdata, m_wdata);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      ram_mem[i] = 8'hC0 | 8'(i);
      exp_mem[i] = 8'hC0 | 8'(i);
    end
    m_addr  = 4'h0;
    m_wdata = 8'h00;
    bus.ram_rdata = 8'h00;
    bus.wr_valid = 1'b1;
    bus.rd_valid = 1'b1;
    bus.wr_addr  = 4'h9;
    bus.wr_data  = 8'h99;
    bus.rd_addr  = 4'h9;

    // Reset held three cycles with both requests pending.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rst_wr_ready", bus.wr_ready, 1'b0);
      chk("rst_rd_ready", bus.rd_ready, 1'b0);
      @(posedge clk);
      #1;
      chk("rst_ram_we", bus.ram_we, 1'b0);
      chk("rst_ram_re", bus.ram_re, 1'b0);
      chk("rst_ram_addr", bus.ram_addr, 4'h0);
      chk("rst_ram_wdata", bus.ram_wdata, 8'h00);
      chk("rst_rdata_valid", bus.rdata_valid, 1'b0);
      chk("rst_rdata", bus.rdata, 8'h00);
    end
    rst = 1'b0;

    // Continuous contention, first contended grant goes to write.
    for (int i = 0; i < 8; i++) begin
`ifdef RAM_ARB_WR_PRIORITY_EN
      step(1'b1, 4'(i), 8'h10 + 8'(i), 1'b1, 4'(i), 1'b1, 1'b0);
`else
      step(1'b1, 4'(i), 8'h10 + 8'(i), 1'b1, 4'(i), (i % 2) == 0, (i % 2) == 1);
`endif
    end
    idle(4);

    // Single write then read of the same address.
    step(1'b1, 4'h5, 8'hA5, 1'b0, 4'h0, 1'b1, 1'b0);
    step(1'b0, 4'h0, 8'h00, 1'b1, 4'h5, 1'b0, 1'b1);
    idle(4);

    // Preload addr^FF, then 16 back-to-back reads.
    for (int i = 0; i < 16; i++) step(1'b1, 4'(i), 8'(i) ^ 8'hFF, 1'b0, 4'h0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 4'h0, 8'h00, 1'b1, 4'(i), 1'b0, 1'b1);
    idle(4);

    // Idle hold after a write.
    step(1'b1, 4'hA, 8'h3C, 1'b0, 4'h0, 1'b1, 1'b0);
    idle(5);

    // Reset the cycle after a read is accepted: the read must vanish.
    step(1'b0, 4'h0, 8'h00, 1'b1, 4'h3, 1'b0, 1'b1);
    rst = 1'b1;
    bus.rd_valid = 1'b0;
    #1;
    chk("mid_rst_rd_ready", bus.rd_ready, 1'b0);
    @(posedge clk);
    #1;
    chk("mid_rst_ram_re", bus.ram_re, 1'b0);
    chk("mid_rst_ram_addr", bus.ram_addr, 4'h0);
    chk("mid_rst_rdata", bus.rdata, 8'h00);
    q.delete();
    m_addr  = 4'h0;
    m_wdata = 8'h00;
    rst = 1'b0;
    idle(5);

    chk("pending_reads", q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Request front-end that sits directly upstream of the single-port synchronous RAM. It accepts independent write and read request channels with valid/ready handshakes and arbitrates between them. The winning request is registered onto the RAM command port, and read data returned by the RAM is presented on a read-response channel with a fixed latency. The RAM agent drives the RAM-side ports of this block unchanged.

## Interface
Parameters:
- DATA_WIDTH, 8, width of write data, RAM data and read data
- ADDR_WIDTH, 4, RAM address width (depth = 2**ADDR_WIDTH)

Ports:
- clk  input  1  single clock; all logic on the rising edge
- rst  input  1  synchronous, active-high reset
- wr_valid  input  1  write request present
- wr_ready  output  1  write request accepted this cycle
- wr_addr  input  ADDR_WIDTH  write address
- wr_data  input  DATA_WIDTH  write data
- rd_valid  input  1  read request present
- rd_ready  output  1  read request accepted this cycle
- rd_addr  input  ADDR_WIDTH  read address
- rdata_valid  output  1  read response valid; single-cycle pulse, no backpressure
- rdata  output  DATA_WIDTH  read response data
- ram_we  output  1  RAM write enable
- ram_re  output  1  RAM read enable
- ram_addr  output  ADDR_WIDTH  RAM address
- ram_wdata  output  DATA_WIDTH  RAM write data
- ram_rdata  input  DATA_WIDTH  RAM read data, valid 1 cycle after ram_re

## Operation
- At most one request is accepted per cycle. A handshake completes when valid && ready.
- Grant logic is combinational from wr_valid/rd_valid and the last-grant flop:
  - only one valid: that channel gets ready=1
  - both valid: round-robin; the channel not granted last time wins
  - neither valid: both readies 0 and the last-grant flop holds
- The last-grant flop updates only on a completed handshake.
- Accepted write: the next cycle drives ram_we=1, ram_re=0, ram_addr=wr_addr, ram_wdata=wr_data.
- Accepted read: the next cycle drives ram_re=1, ram_we=0, ram_addr=rd_addr, ram_wdata holds its previous value.
- No accept: ram_we=ram_re=0; ram_addr and ram_wdata hold.
- Read-return pipeline: a re_d flop captures ram_re. In the cycle re_d=1, rdata_valid=1 and rdata is registered from ram_rdata. rdata holds its value when rdata_valid=0.
- Ordering: commands reach the RAM in acceptance order. A read accepted after a write to the same address returns the new data. No bypass is needed.
- ram_we and ram_re are never both 1.
- Reset:
  - all outputs go to 0: ram_we, ram_re, ram_addr, ram_wdata, rdata_valid, rdata
  - the last-grant flop resets to READ, so the first contended grant goes to write
  - wr_ready and rd_ready are forced to 0 while rst=1
- Reset mid-operation: in-flight commands and reads are dropped. No rdata_valid pulse is produced for any read accepted before reset.

## Timing
- Accept to RAM command: 1 cycle.
- Read accept (cycle N) -> ram_re at N+1 -> rdata_valid/rdata at N+3. ram_rdata is sampled at the end of N+2 and registered.
- Sustained throughput: 1 request per cycle. Under continuous contention, grants alternate W,R,W,R.
- Ready depends combinationally on valid. Requesters must not make valid depend on ready.

## Configuration
- RAM_ARB_WR_PRIORITY_EN:
  - Defined: fixed priority. Write always wins when both are valid, and the last-grant flop is removed.
  - Undefined: round-robin as described above.
- All other behaviour and all latencies are identical in both builds.

## Structure
- The grant encoding typedef (enum GNT_WR/GNT_RD) and the latency constant RD_LAT=3 go in ram_defines.sv, shared with the verification package. The scoreboard uses RD_LAT for response matching.
- One sub-module: ram_rr_arbiter.
  - 2-way grant with last-grant state
  - compiled to fixed priority under RAM_ARB_WR_PRIORITY_EN
  - the top level holds the command register and the read-return pipeline

## Test plan
- Reset check: hold rst 3 cycles with wr_valid=rd_valid=1 -> all outputs 0, both readies 0; first contended cycle after release grants write.
- Single write then read: write addr 4'h5 data 8'hA5, then read 4'h5 -> ram_we at accept+1; rdata_valid with rdata=8'hA5 exactly 3 cycles after the read accept.
- Continuous contention: both valid for 8 cycles with incrementing addresses -> grants alternate W,R,W,R…; 4 rdata_valid pulses in order. Under RAM_ARB_WR_PRIORITY_EN, all 8 cycles grant write and no read is accepted.
- Back-to-back reads: rd_valid=1 for 16 cycles over addr 0..15 after preloading data=addr^8'hFF -> 16 consecutive rdata_valid cycles with matching data.
- Reset mid-read: accept a read at addr 4'h3, assert rst the next cycle -> no rdata_valid pulse follows; ram_re=0.
- Idle hold: no valids for 5 cycles after a write -> ram_addr and ram_wdata hold the last values; ram_we=ram_re=0.
